serial_frame_rx: RTL

- Parametrised symbol-serial frame deserializer for the nibble-programmed CPU's programming path.
- Collects a stream of SYM_W-bit symbols into {addr, cmd, wdata} frames and buffers completed frames in a FIFO.
- Presents frames on a valid/ready interface to the command decoder.
- Compared with the first-generation receiver, it adds:
  - symbol-level ready backpressure;
  - strict per-symbol valid gating;
  - an inter-symbol timeout with partial-frame discard;
  - an explicit abort/resync input;
  - frame and drop counters.

---
 rtl/serial_frame_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Symbol-serial frame deserializer: gathers SYM_W-bit symbols into {wdata, cmd, addr}
// frames and buffers completed frames in a small FIFO for the command decoder.
module serial_frame_rx #(
  parameter int SYM_W      = 4,
  parameter int ADDR_W     = 12,
  parameter int CMD_W      = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              sym_abort,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [CMD_W-1:0]  frame_cmd,
  output logic [DATA_W-1:0] frame_wdata,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int FRAME_W = ADDR_W + CMD_W + DATA_W;
  localparam int N_SYM   = FRAME_W / SYM_W;
  localparam int CNT_W   = $clog2(N_SYM + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  SYM_LAST  = CNT_W'(N_SYM - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               err_q, err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               accept, last_sym, push, pop, drop_evt;
  logic [FRAME_W-1:0] frame_next;

  // Handshakes: a symbol transfers on a rising edge where sym_valid & sym_ready & !sym_abort;
  // a frame transfers where frame_valid & frame_ready. sym_ready depends only on registered
  // occupancy, so a pop frees space for the sender one cycle later.
  assign sym_ready   = (occ_q < OCC_FULL);
  assign frame_valid = (occ_q != '0);
  assign {frame_wdata, frame_cmd, frame_addr} = mem_q[rd_ptr_q];
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;

  always_comb begin
    accept   = sym_valid && sym_ready && !sym_abort;
    last_sym = (sym_cnt_q == SYM_LAST);
    push     = accept && last_sym;
    pop      = frame_valid && frame_ready;

    // The completing symbol is merged here so the full frame is pushed in its own cycle.
    frame_next = asm_q;
    for (int k = 0; k < N_SYM; k++) begin
      if (sym_cnt_q == CNT_W'(k)) frame_next[k*SYM_W +: SYM_W] = sym_in;
    end

    sym_cnt_d   = sym_cnt_q;
    idle_d      = idle_q;
    asm_d       = asm_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    drop_evt    = 1'b0;

    if (sym_abort) begin
      sym_cnt_d = '0;
      idle_d    = '0;
      drop_evt  = (sym_cnt_q != '0);
    end else if (accept) begin
      idle_d = '0;
      asm_d  = frame_next;
      if (last_sym) begin
        sym_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        sym_cnt_d = sym_cnt_q + CNT_W'(1);
      end
    end else if (sym_cnt_q != '0) begin
      // Stalled cycles (sym_ready low) count as idle too.
      if (idle_q == IDLE_LAST) begin
        sym_cnt_d = '0;
        idle_d    = '0;
        err_d     = 1'b1;
        drop_evt  = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end

    if (drop_evt && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q   <= '0;
      idle_q      <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      idle_q      <= idle_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      if (push) mem_q[wr_ptr_q] <= frame_next;
    end
  end

endmodule
